// File: rtl/hidden_cpu_feeder_if.sv
// ---------------------------------------------------------------------------
// hidden_cpu_feeder_if
//   Signal bundle between host/test logic, the feeder and the HiddenCPU pins.
//
//   load_valid/load_ready/load_data/load_last : program load port (6-bit words)
//   start                                     : single-cycle run request
//   pc_in                                     : CPU `out` pins, read as PC
//   cpu_bus                                   : CPU `in` pins {instr, rst, clk}
//   busy/done/halt_cause/step_count           : run status
//   step (FEEDER_SINGLE_STEP_EN only)         : advances one CPU cycle
//
//   slave  : feeder side
//   master : host / CPU side
//
//   Build option: FEEDER_SINGLE_STEP_EN adds the step signal.
// ---------------------------------------------------------------------------
interface hidden_cpu_feeder_if;
  logic       load_valid;
  logic       load_ready;
  logic [5:0] load_data;
  logic       load_last;
  logic       start;
  logic [7:0] pc_in;
  logic [7:0] cpu_bus;
  logic       busy;
  logic       done;
  logic       halt_cause;
  logic [7:0] step_count;
`ifdef FEEDER_SINGLE_STEP_EN
  logic       step;

  modport slave (
    input  load_valid, load_data, load_last, start, pc_in, step,
    output load_ready, cpu_bus, busy, done, halt_cause, step_count
  );

  modport master (
    output load_valid, load_data, load_last, start, pc_in, step,
    input  load_ready, cpu_bus, busy, done, halt_cause, step_count
  );
`else
  modport slave (
    input  load_valid, load_data, load_last, start, pc_in,
    output load_ready, cpu_bus, busy, done, halt_cause, step_count
  );

  modport master (
    output load_valid, load_data, load_last, start, pc_in,
    input  load_ready, cpu_bus, busy, done, halt_cause, step_count
  );
`endif
endinterface

// File: rtl/hidden_cpu_feeder.sv
// ---------------------------------------------------------------------------
// hidden_cpu_feeder
//   Host-side driver for the 8-bit HiddenCPU pin bus. Loads a program of
//   6-bit instructions into a small memory, then resets and clocks the CPU,
//   presenting mem[pc] on every CPU cycle where pc is read back from the
//   CPU's output pins.
//
//   Parameters
//     DEPTH     : program memory entries (power of two, 2..256)
//     HALF      : system clocks per CPU clock phase (>= 2)
//     MAX_STEPS : CPU cycles before a forced halt (1..255)
//
//   Ports
//     clk : system clock
//     rst : asynchronous, active-high reset
//     fb  : hidden_cpu_feeder_if.slave (load port, start, pc_in, cpu_bus,
//           busy/done/halt_cause/step_count)
//
//   Build option: FEEDER_SINGLE_STEP_EN -- when defined, each SETUP phase
//   waits for fb.step after its HALF count before raising the CPU clock.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | ready for load words or a start pulse
// LOAD       | streaming program words into memory
// CPURST_LO  | CPU reset asserted, CPU clock low
// CPURST_HI  | CPU reset asserted, CPU clock high
// SETUP      | CPU clock low, instruction mem[pc_q] presented
// HIGH       | CPU clock high, instruction held; pc sampled at the end
// HALT       | run finished, raise done and return to IDLE
// ---------------------------------------------------------------------------
module hidden_cpu_feeder #(
  parameter int DEPTH     = 16,
  parameter int HALF      = 2,
  parameter int MAX_STEPS = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  hidden_cpu_feeder_if.slave   fb
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (HALF > 2) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CNT_LOAD  = CW'(HALF - 1);
  localparam logic [8:0]    DEPTH9    = 9'(DEPTH);
  localparam logic [7:0]    MAX_STEP8 = 8'(MAX_STEPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CPURST_LO,
    S_CPURST_HI,
    S_SETUP,
    S_HIGH,
    S_HALT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    wr_ptr_q, wr_ptr_d;
  logic [8:0]    prog_len_q, prog_len_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [7:0]    step_count_q, step_count_d;
  logic          halt_cause_q, halt_cause_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          load_ready_q, load_ready_d;
  logic [7:0]    cpu_bus_q, cpu_bus_d;

  logic [5:0]    mem_q [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [5:0]    mem_rd;

  logic          cnt_tc;
  logic          load_fire;
  logic          wr_full;
  logic          setup_go;
  logic [7:0]    step_inc;

  assign cnt_tc    = (cnt_q == '0);
  assign load_fire = fb.load_valid && load_ready_q;
  assign wr_full   = (wr_ptr_q == DEPTH9);
  assign mem_rd    = mem_q[pc_q];
  assign step_inc  = step_count_q + 8'd1;

`ifdef FEEDER_SINGLE_STEP_EN
  assign setup_go = cnt_tc && fb.step;
`else
  assign setup_go = cnt_tc;
`endif

  // Program memory: no reset, contents are undefined until loaded.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= fb.load_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_ptr_d     = wr_ptr_q;
    prog_len_d   = prog_len_q;
    pc_d         = pc_q;
    step_count_d = step_count_q;
    halt_cause_d = halt_cause_q;
    done_d       = done_q;
    mem_we       = 1'b0;
    mem_waddr    = wr_ptr_q[AW-1:0];

    case (state_q)
      S_IDLE: begin
        if (load_fire) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          wr_ptr_d  = 9'd1;
          done_d    = 1'b0;
          // A one-word program completes immediately.
          if (fb.load_last) begin
            prog_len_d = 9'd1;
          end else begin
            state_d = S_LOAD;
          end
        end else if (fb.start) begin
          done_d       = 1'b0;
          step_count_d = 8'd0;
          halt_cause_d = 1'b0;
          if (prog_len_q == 9'd0) begin
            state_d = S_HALT;
          end else begin
            state_d = S_CPURST_LO;
            cnt_d   = CNT_LOAD;
            pc_d    = '0;
          end
        end
      end

      S_LOAD: begin
        if (wr_full) begin
          // Memory full: words are dropped until the last one shows up.
          if (fb.load_valid && fb.load_last) begin
            prog_len_d = DEPTH9;
            state_d    = S_IDLE;
          end
        end else if (load_fire) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 9'd1;
          if (fb.load_last) begin
            prog_len_d = wr_ptr_q + 9'd1;
            state_d    = S_IDLE;
          end
        end
      end

      S_CPURST_LO: begin
        if (cnt_tc) begin
          state_d = S_CPURST_HI;
          cnt_d   = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_CPURST_HI: begin
        if (cnt_tc) begin
          state_d = S_SETUP;
          cnt_d   = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_SETUP: begin
        if (setup_go) begin
          state_d = S_HIGH;
          cnt_d   = CNT_LOAD;
        end else if (!cnt_tc) begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_HIGH: begin
        if (cnt_tc) begin
          // Only the low address bits are kept: pc_q is used solely to
          // address memory, and only while it is inside the program.
          pc_d         = fb.pc_in[AW-1:0];
          step_count_d = step_inc;
          if ({1'b0, fb.pc_in} >= prog_len_q) begin
            state_d      = S_HALT;
            halt_cause_d = 1'b0;
          end else if (step_inc == MAX_STEP8) begin
            state_d      = S_HALT;
            halt_cause_d = 1'b1;
          end else begin
            state_d = S_SETUP;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_HALT: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pin and status outputs follow the current state through one register,
  // so every bus transition lands exactly one clock after the state change.
  always_comb begin
    cpu_bus_d = 8'h00;
    busy_d    = 1'b0;
    case (state_q)
      S_CPURST_LO: begin
        cpu_bus_d = 8'h02;
        busy_d    = 1'b1;
      end
      S_CPURST_HI: begin
        cpu_bus_d = 8'h03;
        busy_d    = 1'b1;
      end
      S_SETUP: begin
        cpu_bus_d = {mem_rd, 2'b00};
        busy_d    = 1'b1;
      end
      S_HIGH: begin
        cpu_bus_d = {cpu_bus_q[7:2], 2'b01};
        busy_d    = 1'b1;
      end
      default: begin
        cpu_bus_d = 8'h00;
        busy_d    = 1'b0;
      end
    endcase
  end

  // Ready is derived from the next state so the word that fills memory
  // also drops ready; no extra word slips in behind it.
  always_comb begin
    load_ready_d = (state_d == S_IDLE) ||
                   ((state_d == S_LOAD) && (wr_ptr_d != DEPTH9));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wr_ptr_q     <= 9'd0;
      prog_len_q   <= 9'd0;
      pc_q         <= '0;
      step_count_q <= 8'd0;
      halt_cause_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      load_ready_q <= 1'b0;
      cpu_bus_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      prog_len_q   <= prog_len_d;
      pc_q         <= pc_d;
      step_count_q <= step_count_d;
      halt_cause_q <= halt_cause_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      load_ready_q <= load_ready_d;
      cpu_bus_q    <= cpu_bus_d;
    end
  end

  assign fb.load_ready = load_ready_q;
  assign fb.cpu_bus    = cpu_bus_q;
  assign fb.busy       = busy_q;
  assign fb.done       = done_q;
  assign fb.halt_cause = halt_cause_q;
  assign fb.step_count = step_count_q;

endmodule

// File: tb/tb_hidden_cpu_feeder.sv
// ---------------------------------------------------------------------------
// tb_hidden_cpu_feeder
//   Drives hidden_cpu_feeder with random programs and a behavioural CPU that
//   returns a precomputed PC sequence. Expected instruction streams, step
//   counts and halt causes come from a program/PC model in this file.
// ---------------------------------------------------------------------------
module tb_hidden_cpu_feeder;
  localparam int DEPTH     = 8;
  localparam int HALF      = 3;
  localparam int MAX_STEPS = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hidden_cpu_feeder_if fb_if ();

  hidden_cpu_feeder #(
    .DEPTH    (DEPTH),
    .HALF     (HALF),
    .MAX_STEPS(MAX_STEPS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fb (fb_if.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Program model
  logic [5:0] prog_mem [DEPTH];
  int         prog_len_m = 0;
  logic [5:0] load_buf [16];

  // CPU model state
  int         pcs [MAX_STEPS];
  int         edge_cnt  = 0;
  int         rst_edges = 0;
  int         rst_rise_cyc = 0;
  int         rise_cyc [$];
  logic [5:0] obs_instr [$];
  logic [7:0] prev_bus = 8'h00;
  logic [5:0] cur_instr = 6'h00;

  // Behavioural CPU: reacts to rising edges of cpu_bus[0].
  always @(negedge clk) begin
    if (rst) begin
      fb_if.pc_in = 8'd0;
      prev_bus    = 8'h00;
    end else begin
      if (fb_if.cpu_bus[0] && !prev_bus[0]) begin
        if (fb_if.cpu_bus[1]) begin
          rst_edges++;
          rst_rise_cyc = cyc;
          chk("rst_hi_bus", fb_if.cpu_bus, 8'h03);
          chk("rst_lo_bus", prev_bus, 8'h02);
          fb_if.pc_in = 8'd0;
        end else begin
          cur_instr = fb_if.cpu_bus[7:2];
          obs_instr.push_back(cur_instr);
          rise_cyc.push_back(cyc);
          fb_if.pc_in = (edge_cnt < MAX_STEPS) ? 8'(pcs[edge_cnt]) : 8'd0;
          edge_cnt++;
        end
      end else if (fb_if.cpu_bus[0] && !fb_if.cpu_bus[1]) begin
        chk("instr_hold", fb_if.cpu_bus[7:2], cur_instr);
      end
      prev_bus = fb_if.cpu_bus;
    end
  end

  task automatic clear_mon();
    edge_cnt  = 0;
    rst_edges = 0;
    obs_instr.delete();
    rise_cyc.delete();
  endtask

  task automatic pulse_start(output int t_s);
    @(negedge clk);
    fb_if.start = 1'b1;
    t_s = cyc + 1;
    @(negedge clk);
    fb_if.start = 1'b0;
  endtask

  task automatic load_prog(input string tag, input int n, input bit poke_start);
    int nst;
    for (int i = 0; i < n; i++) begin
      fb_if.load_valid = 1'b1;
      fb_if.load_data  = load_buf[i];
      fb_if.load_last  = (i == n - 1);
      fb_if.start      = poke_start && (i == 1);
      @(negedge clk);
      chk($sformatf("%s_rdy%0d", tag, i), fb_if.load_ready,
          (i == n - 1) ? 1 : ((i + 1 >= DEPTH) ? 0 : 1));
    end
    fb_if.load_valid = 1'b0;
    fb_if.load_last  = 1'b0;
    fb_if.start      = 1'b0;
    @(negedge clk);
    chk($sformatf("%s_busy", tag), fb_if.busy, 0);
    chk($sformatf("%s_done_clr", tag), fb_if.done, 0);
    nst = (n < DEPTH) ? n : DEPTH;
    for (int i = 0; i < nst; i++) prog_mem[i] = load_buf[i];
    prog_len_m = nst;
  endtask

  task automatic do_run(input string tag, input int mode, input bit poke_start);
    int         exp_steps, exp_cause, pc, t_s, done_cyc, nlast;
    bit         got_done;
    logic [5:0] exp_q [$];
    for (int k = 0; k < MAX_STEPS; k++) begin
      case (mode)
        0:       pcs[k] = k + 1;
        1:       pcs[k] = 0;
        default: pcs[k] = int'($urandom_range(0, prog_len_m));
      endcase
    end
    exp_steps = 0;
    exp_cause = 0;
    pc        = 0;
    if (prog_len_m > 0) begin
      while (1) begin
        exp_q.push_back(prog_mem[pc]);
        exp_steps++;
        pc = pcs[exp_steps - 1];
        if (pc >= prog_len_m) begin
          exp_cause = 0;
          break;
        end
        if (exp_steps == MAX_STEPS) begin
          exp_cause = 1;
          break;
        end
      end
    end
    clear_mon();
    pulse_start(t_s);
    got_done = 0;
    done_cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (fb_if.done) begin
        got_done = 1;
        done_cyc = cyc;
        break;
      end
      fb_if.start = poke_start && (i == 2 * HALF + 3);
      @(negedge clk);
    end
    fb_if.start = 1'b0;
    chk($sformatf("%s_done", tag), got_done, 1);
    chk($sformatf("%s_steps", tag), fb_if.step_count, exp_steps);
    chk($sformatf("%s_cause", tag), fb_if.halt_cause, exp_cause);
    chk($sformatf("%s_busy", tag), fb_if.busy, 0);
    chk($sformatf("%s_edges", tag), edge_cnt, exp_steps);
    chk($sformatf("%s_rst_edges", tag), rst_edges, (prog_len_m > 0) ? 1 : 0);
    for (int k = 0; k < exp_q.size() && k < obs_instr.size(); k++)
      chk($sformatf("%s_instr%0d", tag, k), obs_instr[k], exp_q[k]);
    if (prog_len_m == 0) begin
      chk($sformatf("%s_done_lat", tag), done_cyc - t_s, 1);
    end else if (rst_edges == 1) begin
      chk($sformatf("%s_rst_lat", tag), rst_rise_cyc - t_s, HALF + 1);
      if (rise_cyc.size() > 0) begin
        chk($sformatf("%s_first_lat", tag), rise_cyc[0] - rst_rise_cyc, 2 * HALF);
        for (int k = 1; k < rise_cyc.size(); k++)
          chk($sformatf("%s_period%0d", tag, k), rise_cyc[k] - rise_cyc[k-1], 2 * HALF);
        nlast = rise_cyc.size() - 1;
        chk($sformatf("%s_done_lat", tag), done_cyc - rise_cyc[nlast], HALF);
      end
    end
  endtask

  initial begin
    int  n, mode, t_s;
    bit  hit;
    rst              = 1'b1;
    fb_if.load_valid = 1'b0;
    fb_if.load_data  = 6'h00;
    fb_if.load_last  = 1'b0;
    fb_if.start      = 1'b0;
`ifdef FEEDER_SINGLE_STEP_EN
    fb_if.step = 1'b1;
`endif
    repeat (2) @(negedge clk);
    chk("rst_bus", fb_if.cpu_bus, 8'h00);
    chk("rst_busy", fb_if.busy, 0);
    chk("rst_done", fb_if.done, 0);
    chk("rst_cause", fb_if.halt_cause, 0);
    chk("rst_steps", fb_if.step_count, 0);
    chk("rst_ready", fb_if.load_ready, 0);
    rst = 1'b0;
    #1;
    chk("rel_ready0", fb_if.load_ready, 0);
    @(negedge clk);
    chk("rel_ready1", fb_if.load_ready, 1);

    // Empty program: immediate halt with cause 0.
    prog_len_m = 0;
    do_run("empty", 0, 0);

    // Fixed three-word program, sequential PC, start poked mid-run.
    load_buf[0] = 6'h05;
    load_buf[1] = 6'h1A;
    load_buf[2] = 6'h30;
    load_prog("ld3", 3, 0);
    do_run("seq3", 0, 1);

    // PC stuck at 0 runs into the step limit.
    load_buf[0] = 6'($urandom);
    load_buf[1] = 6'($urandom);
    load_prog("ld2", 2, 0);
    do_run("maxstep", 1, 0);

    // Overflowing load with start poked during LOAD.
    for (int i = 0; i < DEPTH + 2; i++) load_buf[i] = 6'($urandom);
    load_prog("ovf", DEPTH + 2, 1);
    do_run("ovf_run", 0, 0);

    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(2, DEPTH + 2));
      for (int i = 0; i < n; i++) load_buf[i] = 6'($urandom);
      load_prog($sformatf("rld%0d", r), n, $urandom_range(0, 1) == 1);
      mode = int'($urandom_range(0, 2));
      do_run($sformatf("rrun%0d", r), mode, $urandom_range(0, 1) == 1);
    end

`ifdef FEEDER_SINGLE_STEP_EN
    for (int i = 0; i < 3; i++) load_buf[i] = 6'($urandom);
    load_prog("ss_ld", 3, 0);
    for (int k = 0; k < MAX_STEPS; k++) pcs[k] = k + 1;
    clear_mon();
    fb_if.step = 1'b0;
    pulse_start(t_s);
    repeat (40) @(negedge clk);
    chk("ss_rst_edges", rst_edges, 1);
    chk("ss_no_edge", edge_cnt, 0);
    chk("ss_clk_low", fb_if.cpu_bus[0], 0);
    fb_if.step = 1'b1;
    @(negedge clk);
    fb_if.step = 1'b0;
    repeat (6 * HALF) @(negedge clk);
    chk("ss_one_edge", edge_cnt, 1);
    fb_if.step = 1'b1;
    hit = 0;
    for (int i = 0; i < 500; i++) begin
      if (fb_if.done) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    chk("ss_done", hit, 1);
    chk("ss_steps", fb_if.step_count, 3);
`endif

    // Reset in the middle of a HIGH phase.
    for (int i = 0; i < 3; i++) load_buf[i] = 6'($urandom);
    load_prog("mr_ld", 3, 0);
    for (int k = 0; k < MAX_STEPS; k++) pcs[k] = 0;
    clear_mon();
    pulse_start(t_s);
    hit = 0;
    for (int i = 0; i < 500; i++) begin
      if (fb_if.cpu_bus[0] && !fb_if.cpu_bus[1]) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    chk("mr_high_seen", hit, 1);
    rst = 1'b1;
    #1;
    chk("mr_bus", fb_if.cpu_bus, 8'h00);
    chk("mr_busy", fb_if.busy, 0);
    chk("mr_steps", fb_if.step_count, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_ready0", fb_if.load_ready, 0);
    @(negedge clk);
    chk("mr_ready1", fb_if.load_ready, 1);
    prog_len_m = 0;
    do_run("mr_empty", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
